exception_vector_unit: RTL

//  Upstream feeder of the PC-source selector's exception inputs (select 00 and 01).
//  On an exception request it captures EPC = PC-4 and reads the handler byte from memory.
//  The byte comes from address 253/254/255 by cause. It zero-extends the byte to 32 bits,

---
 rtl/exc_pkg.sv | 14 +
 rtl/exception_vector_unit_if.sv | 18 +
 rtl/exception_vector_unit.sv | 58 +++++
 3 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: cause encodings, default handler-byte addresses and FSM states
package exc_pkg;
    localparam logic [1:0] CAUSE_OPCODE = 2'b00;
    localparam logic [1:0] CAUSE_OVF    = 2'b01;
    localparam logic [1:0] CAUSE_DIVZ   = 2'b10;
    localparam logic [7:0] VEC_OPCODE_DEF   = 8'd253;
    localparam logic [7:0] VEC_OVERFLOW_DEF = 8'd254;
    localparam logic [7:0] VEC_DIVZERO_DEF  = 8'd255;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_DONE} state_e;
    // the unused encoding 11 is treated as an invalid opcode
    function automatic logic [1:0] norm_cause(input logic [1:0] c);
        return c == 2'b11 ? CAUSE_OPCODE : c;
    endfunction
endpackage

// File: rtl/exception_vector_unit_if.sv
// exception_vector_unit_if: control, memory and PC-source signals of the exception unit
interface exception_vector_unit_if;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [31:0] pc_in;
    logic [7:0]  mem_data;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] exc_destiny;
    logic [31:0] epc_out;
    logic [1:0]  cause_out;
    logic        exc_busy;
    logic        exc_done;
    modport master (output exc_req, exc_cause, pc_in, mem_data,
                    input mem_addr, mem_rd, exc_destiny, epc_out, cause_out, exc_busy, exc_done);
    modport slave  (input exc_req, exc_cause, pc_in, mem_data,
                    output mem_addr, mem_rd, exc_destiny, epc_out, cause_out, exc_busy, exc_done);
endinterface

// File: rtl/exception_vector_unit.sv
// exception_vector_unit: saves EPC, fetches the handler byte for the cause and
// presents it zero-extended as the exception destination
module exception_vector_unit
    import exc_pkg::*;
#(
    parameter int         MEM_LATENCY  = 1,
    parameter logic [7:0] VEC_OPCODE   = VEC_OPCODE_DEF,
    parameter logic [7:0] VEC_OVERFLOW = VEC_OVERFLOW_DEF,
    parameter logic [7:0] VEC_DIVZERO  = VEC_DIVZERO_DEF
) (
    input logic                     clk,
    input logic                     reset,
    exception_vector_unit_if.slave  bus
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    state_e state, next;
    logic [CW-1:0] cnt;
    logic [1:0] cause_n;
    logic [7:0] vec;
    logic accept, last;
    assign cause_n = norm_cause(bus.exc_cause);
    assign vec = cause_n == CAUSE_OVF ? VEC_OVERFLOW : cause_n == CAUSE_DIVZ ? VEC_DIVZERO : VEC_OPCODE;
    assign accept = state == S_IDLE && bus.exc_req;
    assign last = state == S_WAIT && cnt == CW'(1);
    assign bus.exc_busy = state != S_IDLE;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= next;
    always_comb begin
        next = state;
        next = state == S_IDLE ? (bus.exc_req ? S_READ : S_IDLE)
             : state == S_READ ? S_WAIT
             : state == S_WAIT ? (last ? S_DONE : S_WAIT)
             : S_IDLE;
    end
    // strobe and address are registered on acceptance so they are high exactly during READ
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt             <= '0;
            bus.mem_rd      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.exc_done    <= 1'b0;
            bus.exc_destiny <= '0;
            bus.epc_out     <= '0;
            bus.cause_out   <= '0;
        end else begin
            bus.mem_rd   <= accept;
            bus.mem_addr <= accept ? {24'b0, vec} : '0;
            bus.exc_done <= last;
            if (accept) begin
                bus.cause_out <= cause_n;
                bus.epc_out   <= bus.pc_in - 32'd4;
            end
            if (state == S_READ) cnt <= CW'(MEM_LATENCY);
            else if (state == S_WAIT) cnt <= cnt - CW'(1);
            if (last) bus.exc_destiny <= {24'b0, bus.mem_data};
        end
endmodule
